// File: rtl/sad_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sad_pkg                                            |
// | Description : Shared types and sizes for the SAD block memory.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package sad_pkg;

    localparam int SAD_DEPTH = 256;
    localparam int SAD_AW    = 9;
    localparam int SAD_DW    = 8;

    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_FULL   = 2'd2
    } sad_mem_state_t;

endpackage
`default_nettype wire

// File: rtl/sad_bram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sad_bram                                           |
// | Description : Single-write, registered-read RAM with read enable |
// |               and a synchronous output clear.                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sad_bram #(
    parameter int DEPTH = 256,
    parameter int W     = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [PW-1:0] raddr,
    input  logic          clr,
    output logic [W-1:0]  rdata
);

    // Storage is deliberately not reset; the owner gates reads by state.
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= clr ? '0 : r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sad_block_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sad_block_mem                                      |
// | Description : A/B pixel block buffer for the SAD engine, filled  |
// |               from a byte stream. Optional SAD_MEM_PARITY_EN.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sad_block_mem
    import sad_pkg::*;
#(
    parameter int DEPTH = SAD_DEPTH,
    parameter int AW    = SAD_AW,
    parameter int DW    = SAD_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          blk_ready,
    input  logic          blk_done,
    input  logic          AB_rd,
    input  logic [AW-1:0] AB_adrr,
    output logic [DW-1:0] A_data,
    output logic [DW-1:0] B_data
`ifdef SAD_MEM_PARITY_EN
    ,
    output logic          par_err
`endif
);

    localparam int c_PW = $clog2(DEPTH);
`ifdef SAD_MEM_PARITY_EN
    localparam int c_MW = DW + 1;
`else
    localparam int c_MW = DW;
`endif
    localparam logic [c_PW-1:0] c_LAST    = c_PW'(DEPTH - 1);
    localparam logic [AW-1:0]   c_DEPTH_A = AW'(DEPTH);

    sad_mem_state_t    r_state, w_state_nxt;
    logic [c_PW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic              r_ld_ready;
    logic              w_accept, w_we_a, w_we_b, w_rd_ok;
    logic [c_MW-1:0]   w_wdata, w_a_q, w_b_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_we_a       = 1'b0;
        w_we_b       = 1'b0;
        w_accept     = ld_valid & r_ld_ready;
        case (r_state)
            S_LOAD_A: begin
                if (w_accept) begin
                    w_we_a = 1'b1;
                    if (r_wr_ptr == c_LAST) begin
                        w_state_nxt  = S_LOAD_B;
                        w_wr_ptr_nxt = '0;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + c_PW'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (w_accept) begin
                    w_we_b = 1'b1;
                    if (r_wr_ptr == c_LAST) begin
                        w_state_nxt  = S_FULL;
                        w_wr_ptr_nxt = '0;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + c_PW'(1);
                    end
                end
            end
            S_FULL: begin
                if (blk_done) begin
                    w_state_nxt  = S_LOAD_A;
                    w_wr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = S_LOAD_A;
                w_wr_ptr_nxt = '0;
            end
        endcase
    end

    // ld_ready is registered so it stays low throughout reset and tracks the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD_A;
            r_wr_ptr   <= '0;
            r_ld_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_ld_ready <= (w_state_nxt != S_FULL);
        end
    end

    assign ld_ready  = r_ld_ready;
    assign blk_ready = (r_state == S_FULL);
    assign w_rd_ok   = (r_state == S_FULL) && (AB_adrr < c_DEPTH_A);

`ifdef SAD_MEM_PARITY_EN
    logic r_rd_served, r_par_sticky, w_par_now;

    assign w_wdata   = {^ld_data, ld_data};
    // Even parity: a served word with odd total weight is corrupt.
    assign w_par_now = r_rd_served & ((^w_a_q) | (^w_b_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_served  <= 1'b0;
            r_par_sticky <= 1'b0;
        end else begin
            r_rd_served <= AB_rd & w_rd_ok;
            if (blk_done && (r_state == S_FULL)) begin
                r_par_sticky <= 1'b0;
            end else if (w_par_now) begin
                r_par_sticky <= 1'b1;
            end
        end
    end

    assign par_err = r_par_sticky | w_par_now;
`else
    assign w_wdata = ld_data;
`endif

    sad_bram #(.DEPTH(DEPTH), .W(c_MW)) u_mem_a (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we_a),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .re    (AB_rd),
        .raddr (AB_adrr[c_PW-1:0]),
        .clr   (~w_rd_ok),
        .rdata (w_a_q)
    );

    sad_bram #(.DEPTH(DEPTH), .W(c_MW)) u_mem_b (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we_b),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .re    (AB_rd),
        .raddr (AB_adrr[c_PW-1:0]),
        .clr   (~w_rd_ok),
        .rdata (w_b_q)
    );

    assign A_data = w_a_q[DW-1:0];
    assign B_data = w_b_q[DW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_sad_block_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_sad_block_mem                                   |
// | Description : Directed self-checking bench for sad_block_mem.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_sad_block_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] ld_data = 8'h00;
    logic       blk_ready;
    logic       blk_done = 1'b0;
    logic       AB_rd = 1'b0;
    logic [8:0] AB_adrr = 9'h000;
    logic [7:0] A_data, B_data;
`ifdef SAD_MEM_PARITY_EN
    logic       par_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sad_block_mem dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .blk_ready (blk_ready),
        .blk_done  (blk_done),
        .AB_rd     (AB_rd),
        .AB_adrr   (AB_adrr),
        .A_data    (A_data),
        .B_data    (B_data)
`ifdef SAD_MEM_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    // mode 0: A = 0..255, B = 255..0; mode 1: distinct xor pattern for reload checks
    function automatic logic [7:0] pattern(input int cnt, input int mode);
        logic [8:0] c;
        c = cnt[8:0];
        if (mode == 0) return (cnt < 256) ? c[7:0] : 8'(511 - cnt);
        return c[7:0] ^ (c[8] ? 8'hC3 : 8'h5A);
    endfunction

    task automatic load_bytes(input int n, input int mode, input bit toggle,
                              input bit poke_done, output bit early_full);
        int cnt = 0;
        int cyc = 0;
        bit v;
        early_full = 1'b0;
        while (cnt < n && cyc < 4000) begin
            @(negedge clk);
            v        = toggle ? (cyc % 2 == 0) : 1'b1;
            ld_valid = v;
            ld_data  = pattern(cnt, mode);
            blk_done = poke_done && (cyc == 40);
            if (blk_ready) early_full = 1'b1;
            if (v && ld_ready) cnt++;
            cyc++;
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        blk_done = 1'b0;
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL load_budget accepted=%0d required=%0d", cnt, n);
        end
    endtask

    task automatic do_read(input logic [8:0] addr, input logic done);
        @(negedge clk);
        AB_rd    = 1'b1;
        AB_adrr  = addr;
        blk_done = done;
        @(negedge clk);
        AB_rd    = 1'b0;
        blk_done = 1'b0;
    endtask

    task automatic check_ab(input string name, input logic [7:0] ea, input logic [7:0] eb);
        checks++;
        if (A_data !== ea || B_data !== eb) begin
            errors++;
            $display("FAIL %s A=%h B=%h required A=%h B=%h", name, A_data, B_data, ea, eb);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (ld_ready !== 1'b0 || blk_ready !== 1'b0 || A_data !== 8'h00 || B_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state ld_ready=%b blk_ready=%b A=%h B=%h required 0 0 00 00",
                     ld_ready, blk_ready, A_data, B_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ld_ready=%b required 1", ld_ready);
        end
    endtask

    task automatic test_stream_load();
        bit early;
        load_bytes(512, 0, 1'b0, 1'b0, early);
        checks++;
        if (early) begin
            errors++;
            $display("FAIL early_blk_ready seen=1 required 0");
        end
        checks++;
        if (blk_ready !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_after_512 blk_ready=%b ld_ready=%b required 1 0", blk_ready, ld_ready);
        end
        // Extra bytes offered while full must be refused.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        repeat (3) @(negedge clk);
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refuses ld_ready=%b required 0", ld_ready);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_read();
        do_read(9'h005, 1'b0);
        check_ab("read_5", 8'h05, 8'hFA);
        repeat (3) @(negedge clk);
        check_ab("hold_rd0", 8'h05, 8'hFA);
        do_read(9'h100, 1'b0);
        check_ab("read_oob_100", 8'h00, 8'h00);
        do_read(9'h000, 1'b0);
        check_ab("read_0", 8'h00, 8'hFF);
        do_read(9'h0FF, 1'b0);
        check_ab("read_255", 8'hFF, 8'h00);
    endtask

    task automatic test_back_to_back();
        do_read(9'h003, 1'b1);
        check_ab("read_with_done", 8'h03, 8'hFC);
        checks++;
        if (blk_ready !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_frees blk_ready=%b ld_ready=%b required 0 1", blk_ready, ld_ready);
        end
        do_read(9'h003, 1'b0);
        check_ab("read_in_load_a", 8'h00, 8'h00);
    endtask

    task automatic test_toggle_load();
        bit early;
        load_bytes(512, 0, 1'b1, 1'b1, early);
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL toggle_full blk_ready=%b required 1", blk_ready);
        end
        do_read(9'h00A, 1'b0);
        check_ab("toggle_read_10", 8'h0A, 8'hF5);
        do_read(9'h0C8, 1'b0);
        check_ab("toggle_read_200", 8'hC8, 8'h37);
        do_read(9'h1FF, 1'b0);
        check_ab("read_oob_1ff", 8'h00, 8'h00);
        pulse_done();
    endtask

    task automatic test_reset_midload();
        bit early;
        load_bytes(356, 0, 1'b0, 1'b0, early);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || blk_ready !== 1'b0 || A_data !== 8'h00 || B_data !== 8'h00) begin
            errors++;
            $display("FAIL midload_reset ld_ready=%b blk_ready=%b A=%h B=%h required 0 0 00 00",
                     ld_ready, blk_ready, A_data, B_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ld_ready !== 1'b1 || blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL midload_release ld_ready=%b blk_ready=%b required 1 0", ld_ready, blk_ready);
        end
        load_bytes(512, 1, 1'b0, 1'b0, early);
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_full blk_ready=%b required 1", blk_ready);
        end
        do_read(9'h000, 1'b0);
        check_ab("reload_read_0", 8'h5A, 8'hC3);
        do_read(9'h064, 1'b0);
        check_ab("reload_read_100", 8'h3E, 8'hA7);
        do_read(9'h0FF, 1'b0);
        check_ab("reload_read_255", 8'hA5, 8'h3C);
    endtask

`ifdef SAD_MEM_PARITY_EN
    task automatic test_parity();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_clean par_err=%b required 0", par_err);
        end
        dut.u_mem_a.r_mem[7] = dut.u_mem_a.r_mem[7] ^ 9'h001;
        do_read(9'h007, 1'b0);
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_detect par_err=%b required 1", par_err);
        end
        do_read(9'h006, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_sticky par_err=%b required 1", par_err);
        end
        pulse_done();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_clear par_err=%b required 0", par_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream_load();
        test_read();
        test_back_to_back();
        test_toggle_load();
        test_reset_midload();
`ifdef SAD_MEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
